data_memory_ctrl: RTL and testbench

// - Parametrised data memory for the ARM datapath. Services LDR/STR-class accesses at byte, halfword and word size.
// - Little-endian, byte-addressed. Supports sign or zero extension on loads.
// - Requests use a req/ready handshake with configurable wait states. Misaligned and out-of-range accesses raise a fault.
// - Contents are cleared after reset by a sequential init sweep. Sits between the execute/memory stage and the writeback mux.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 39 +++
 rtl/data_memory_ctrl.sv | 136 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_e;

  // Byte accesses are always aligned; the reserved size is flagged separately.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store merge into an existing word and load extraction with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        sign_ext_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word_i[{lane_i, 3'b000} +: 8];
  assign half_v = word_i[{lane_i[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch appears.
  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

  always_comb begin
    load_o = word_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
      SZ_HALF: load_o = {{16{sign_ext_i & half_v[15]}}, half_v};
      default: load_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with req/ready handshake, wait states,
// fault detection and a post-reset clearing sweep.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int INIT_CLEAR  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write_en,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        busy
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_e        state_q;
  logic [AW-1:0] init_cnt_q;
  logic [3:0]    wait_cnt_q;
  logic          we_q, sext_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   rdata_q;
  logic          ready_q, fault_q, busy_q;
  logic [31:0]   mem_q [DEPTH];

  // With zero wait states the access executes on the accepting edge, so IDLE uses the live request.
  logic          in_idle, exec;
  logic          cur_we, cur_sext, cur_fault;
  logic [1:0]    cur_size, cur_lane;
  logic [31:0]   cur_addr, cur_wdata;
  logic [AW-1:0] cur_idx;
  logic [31:0]   merged_word, load_data;

  assign in_idle   = (state_q == IDLE);
  assign cur_we    = in_idle ? write_en : we_q;
  assign cur_sext  = in_idle ? sign_ext : sext_q;
  assign cur_size  = in_idle ? size     : size_q;
  assign cur_addr  = in_idle ? addr     : addr_q;
  assign cur_wdata = in_idle ? wdata    : wdata_q;
  assign cur_idx   = cur_addr[AW+1:2];
  assign cur_lane  = cur_addr[1:0];
  assign cur_fault = (cur_size == 2'b11) || is_misaligned(cur_size, cur_lane) ||
                     (|cur_addr[31:AW+2]);
  assign exec      = (in_idle && req && (WAIT_STATES == 0)) ||
                     ((state_q == WAIT) && (wait_cnt_q == 4'd0));

  dmem_lane_align u_align (
    .word_i     (mem_q[cur_idx]),
    .wdata_i    (cur_wdata),
    .size_i     (cur_size),
    .lane_i     (cur_lane),
    .sign_ext_i (cur_sext),
    .merged_o   (merged_word),
    .load_o     (load_data)
  );

  // NOTE: the array is deliberately not reset; the INIT sweep clears it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem_q[init_cnt_q] <= '0;
      end else if (exec && !cur_fault && cur_we) begin
        mem_q[cur_idx] <= merged_word;
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= (INIT_CLEAR != 0) ? INIT : IDLE;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= (INIT_CLEAR != 0);
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      if (exec) begin
        ready_q <= 1'b1;
        fault_q <= cur_fault;
        rdata_q <= (cur_fault || cur_we) ? 32'h0 : load_data;
      end
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (req) begin
            we_q       <= write_en;
            size_q     <= size;
            sext_q     <= sign_ext;
            addr_q     <= addr;
            wdata_q    <= wdata;
            busy_q     <= 1'b1;
            wait_cnt_q <= WAIT_LOAD;
            state_q    <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 4'd0) state_q <= RESP;
          else                    wait_cnt_q <= wait_cnt_q - 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign fault = fault_q;
  assign busy  = busy_q | reset;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: one instance with no wait states, one with three, sharing stimulus via a select.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset, req, sel, write_en, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata0, rdata3;
  logic        ready0, fault0, busy0, ready3, fault3, busy3;
  logic        req0, req3, ready_m, fault_m, busy_m;
  logic [31:0] rdata_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign req0    = req & ~sel;
  assign req3    = req &  sel;
  assign ready_m = sel ? ready3 : ready0;
  assign fault_m = sel ? fault3 : fault0;
  assign busy_m  = sel ? busy3  : busy0;
  assign rdata_m = sel ? rdata3 : rdata0;

  data_memory_ctrl #(.DEPTH(256), .WAIT_STATES(0), .INIT_CLEAR(1)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .write_en(write_en), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .fault(fault0), .busy(busy0)
  );

  data_memory_ctrl #(.DEPTH(256), .WAIT_STATES(3), .INIT_CLEAR(1)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .write_en(write_en), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .ready(ready3), .fault(fault3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Holds req through the whole sweep and measures its length on the selected instance.
  task automatic sweep(input string tag);
    int n    = 0;
    int seen = 0;
    req = 1'b1;
    while (busy_m && n < 1000) begin
      @(negedge clk);
      n++;
      if (ready_m) seen++;
    end
    req = 1'b0;
    check({tag, "_len"}, n, 256);
    check({tag, "_req_ignored"}, seen, 0);
  endtask

  task automatic op(input string tag, input logic s, input logic we, input logic [1:0] sz,
                    input logic sx, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_flt);
    logic [31:0] rd;
    logic        flt;
    int          lat;
    sel = s; write_en = we; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready_m && lat < 40);
    req = 1'b0;
    rd  = rdata_m;
    flt = fault_m;
    check({tag, "_lat"}, lat, s ? 4 : 1);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_fault"}, {31'b0, flt}, {31'b0, exp_flt});
    @(negedge clk);
    check({tag, "_strobe"}, {31'b0, ready_m}, 32'h0);
  endtask

  initial begin
    logic [14:0] mask;
    reset = 1'b1; req = 1'b0; sel = 1'b0; write_en = 1'b0; size = 2'b10;
    sign_ext = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata_m, 32'h0);
    check("rst_ready", {31'b0, ready_m}, 32'h0);
    check("rst_fault", {31'b0, fault_m}, 32'h0);
    check("rst_busy0", {31'b0, busy0}, 32'h1);
    check("rst_busy3", {31'b0, busy3}, 32'h1);
    reset = 1'b0;
    sweep("init");

    op("ld_0x000", 0, 0, 2'b10, 0, 32'h000, 32'h0, 32'h0, 0);
    op("ld_0x3fc", 0, 0, 2'b10, 0, 32'h3FC, 32'h0, 32'h0, 0);
    op("st_beef",  0, 1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h0, 0);
    op("ld_beef",  0, 0, 2'b10, 0, 32'h010, 32'h0, 32'hDEADBEEF, 0);
    op("st_1122",  0, 1, 2'b10, 0, 32'h010, 32'h11223344, 32'h0, 0);
    op("st_b80",   0, 1, 2'b00, 0, 32'h013, 32'hFFFFFF80, 32'h0, 0);
    op("ld_w_b80", 0, 0, 2'b10, 0, 32'h010, 32'h0, 32'h80223344, 0);
    op("ld_b_sx",  0, 0, 2'b00, 1, 32'h013, 32'h0, 32'hFFFFFF80, 0);
    op("ld_b_zx",  0, 0, 2'b00, 0, 32'h013, 32'h0, 32'h00000080, 0);
    op("ld_h_sx",  0, 0, 2'b01, 1, 32'h012, 32'h0, 32'hFFFF8022, 0);
    op("ld_h_zx",  0, 0, 2'b01, 0, 32'h012, 32'h0, 32'h00008022, 0);
    op("st_h_mis", 0, 1, 2'b01, 0, 32'h011, 32'h00005555, 32'h0, 1);
    op("ld_after_mis", 0, 0, 2'b10, 0, 32'h010, 32'h0, 32'h80223344, 0);
    op("st_h_lo",  0, 1, 2'b01, 0, 32'h010, 32'h0000ABCD, 32'h0, 0);
    op("ld_w_h",   0, 0, 2'b10, 0, 32'h010, 32'h0, 32'h8022ABCD, 0);
    op("ld_b1_sx", 0, 0, 2'b00, 1, 32'h011, 32'h0, 32'hFFFFFFAB, 0);
    op("ld_range", 0, 0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1);
    op("ld_hibit", 0, 0, 2'b00, 0, 32'h8000_0010, 32'h0, 32'h0, 1);
    op("ld_sz11",  0, 0, 2'b11, 0, 32'h010, 32'h0, 32'h0, 1);
    op("ld_w_mis", 0, 0, 2'b10, 0, 32'h012, 32'h0, 32'h0, 1);
    op("st_range", 0, 1, 2'b10, 0, 32'h410, 32'h01234567, 32'h0, 1);
    op("ld_alias", 0, 0, 2'b10, 0, 32'h010, 32'h0, 32'h8022ABCD, 0);

    op("ws3_st",   1, 1, 2'b10, 0, 32'h020, 32'h12345678, 32'h0, 0);
    op("ws3_ld",   1, 0, 2'b10, 0, 32'h020, 32'h0, 32'h12345678, 0);

    // req held high: responses must be spaced by 2+WAIT_STATES cycles.
    sel = 1'b1; write_en = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h020; req = 1'b1;
    mask = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (ready_m) mask[k-1] = 1'b1;
    end
    req = 1'b0;
    check("ws3_pulses", {17'b0, mask}, 32'h0000_2108);
    @(negedge clk);
    check("ws3_idle", {31'b0, busy_m}, 32'h0);

    // Reset while a store waits: the write edge never happens, then the sweep restarts.
    sel = 1'b1; write_en = 1'b1; size = 2'b10; addr = 32'h020; wdata = 32'hCAFEF00D; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_ready", {31'b0, ready_m}, 32'h0);
    check("rstw_busy", {31'b0, busy_m}, 32'h1);
    check("rstw_word", u_dut3.mem_q[8], 32'h12345678);
    reset = 1'b0;
    sweep("reinit");
    op("ws3_ld_clr", 1, 0, 2'b10, 0, 32'h020, 32'h0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
